// File: rtl/arith_result_queue.sv
// In-order result queue for the 16-bit arithmetic unit, with sticky status flags,
// an accepted-operation counter and a saturating error counter.
module arith_result_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_sel_arith,
    input  logic [WIDTH-1:0]         in_result,
    input  logic [WIDTH-1:0]         in_upper,
    input  logic [WIDTH-1:0]         in_remainder,
    input  logic [3:0]               in_flags,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               out_sel_arith,
    output logic [WIDTH-1:0]         out_result,
    output logic [WIDTH-1:0]         out_upper,
    output logic [WIDTH-1:0]         out_remainder,
    output logic [3:0]               out_flags,
    output logic [$clog2(DEPTH):0]   count,
    output logic [3:0]               sticky_flags,
    input  logic                     sticky_clear,
    output logic [15:0]              op_count,
    output logic [7:0]               err_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned EntW = 2 + 3 * WIDTH + 4;
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    logic [EntW-1:0] mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [3:0]      sticky_q, sticky_d;
    logic [15:0]     op_cnt_q, op_cnt_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic            push, pop;

    // Handshake decodes depend only on registered occupancy.
    assign in_ready  = (count_q != CntFull);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign {out_sel_arith, out_result, out_upper, out_remainder, out_flags} = mem_q[rd_ptr_q];
    assign count        = count_q;
    assign sticky_flags = sticky_q;
    assign op_count     = op_cnt_q;
    assign err_count    = err_cnt_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        sticky_d  = sticky_q;
        op_cnt_d  = op_cnt_q;
        err_cnt_d = err_cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        // A clear coinciding with a push keeps the new entry's flags.
        if (push) begin
            sticky_d = (sticky_clear ? 4'b0000 : sticky_q) | in_flags;
        end else if (sticky_clear) begin
            sticky_d = 4'b0000;
        end

        if (push) begin
            op_cnt_d = op_cnt_q + 16'd1;
            if ((in_flags[1] || in_flags[0]) && (err_cnt_q != 8'hFF)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            sticky_q  <= '0;
            op_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {in_sel_arith, in_result, in_upper, in_remainder, in_flags};
            end
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            sticky_q  <= sticky_d;
            op_cnt_q  <= op_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_arith_result_queue.sv
// Directed bench for arith_result_queue: ordering, full/empty behaviour, sticky flags,
// counters and mid-operation reset, with hand-computed expectations.
module tb_arith_result_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_sel_arith;
    logic [15:0] in_result;
    logic [15:0] in_upper;
    logic [15:0] in_remainder;
    logic [3:0]  in_flags;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_sel_arith;
    logic [15:0] out_result;
    logic [15:0] out_upper;
    logic [15:0] out_remainder;
    logic [3:0]  out_flags;
    logic [2:0]  count;
    logic [3:0]  sticky_flags;
    logic        sticky_clear;
    logic [15:0] op_count;
    logic [7:0]  err_count;

    int vectors = 0;
    int miscompares = 0;

    arith_result_queue #(.DEPTH(4), .WIDTH(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sel_arith  (in_sel_arith),
        .in_result     (in_result),
        .in_upper      (in_upper),
        .in_remainder  (in_remainder),
        .in_flags      (in_flags),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_sel_arith (out_sel_arith),
        .out_result    (out_result),
        .out_upper     (out_upper),
        .out_remainder (out_remainder),
        .out_flags     (out_flags),
        .count         (count),
        .sticky_flags  (sticky_flags),
        .sticky_clear  (sticky_clear),
        .op_count      (op_count),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Producer rule: a stalled offer must be held unchanged until accepted.
    logic        pend = 1'b0;
    logic [15:0] pend_res = '0;
    always @(posedge clk) begin
        if (rst_n && pend) begin
            vectors++;
            assert (in_valid === 1'b1 && in_result === pend_res)
            else begin
                miscompares++;
                $error("FAIL producer_hold: observed valid=%0b res=%0h expected valid=1 res=%0h",
                       in_valid, in_result, pend_res);
            end
        end
        pend     = rst_n && in_valid && !in_ready;
        pend_res = in_result;
    end

    task automatic drive(input logic [1:0] sel, input logic [15:0] res, input logic [15:0] up,
                         input logic [15:0] rem, input logic [3:0] fl);
        in_sel_arith = sel;
        in_result    = res;
        in_upper     = up;
        in_remainder = rem;
        in_flags     = fl;
    endtask

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        sticky_clear = 1'b0;
        drive(2'd0, 16'd0, 16'd0, 16'd0, 4'b0000);
        step();
        step();
        rst_n = 1'b1;

        // Reset state
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_flags", out_flags, 0);
        chk("rst_sticky", sticky_flags, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_err_count", err_count, 0);

        // Add path: 1234 + 4321
        drive(2'd0, 16'd5555, 16'd0, 16'd0, 4'b0000);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("add_out_valid", out_valid, 1);
        chk("add_out_result", out_result, 16'd5555);
        chk("add_count", count, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("add_pop_count", count, 0);
        chk("add_op_count", op_count, 1);
        chk("add_empty_valid", out_valid, 0);

        // Division by zero, then 1000/10
        drive(2'd3, 16'd0, 16'd0, 16'd0, 4'b0010);
        in_valid = 1'b1;
        step();
        chk("dbz_sticky", sticky_flags, 4'b0010);
        chk("dbz_err", err_count, 1);
        drive(2'd3, 16'd100, 16'd0, 16'd0, 4'b0000);
        step();
        in_valid = 1'b0;
        chk("div_sticky", sticky_flags, 4'b0010);
        chk("div_err", err_count, 1);
        chk("div_count", count, 2);
        chk("div_head_sel", out_sel_arith, 2'd3);
        chk("div_head_flags", out_flags, 4'b0010);
        out_ready = 1'b1;
        step();
        chk("div_head2_result", out_result, 16'd100);
        chk("div_head2_rem", out_remainder, 16'd0);
        step();
        out_ready = 1'b0;
        chk("div_drain_count", count, 0);

        // Fill and order
        for (int i = 1; i <= 4; i++) begin
            drive(2'd2, 16'(i), 16'(i * 256), 16'd0, 4'b0000);
            in_valid = 1'b1;
            step();
        end
        chk("fill_count", count, 4);
        chk("fill_in_ready", in_ready, 0);
        drive(2'd2, 16'd5, 16'h0500, 16'd0, 4'b0000);
        step();
        step();
        step();
        chk("full_hold_count", count, 4);
        chk("full_hold_op", op_count, 7);
        out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            chk("order_result", out_result, 32'(k));
            chk("order_upper", out_upper, 32'(k * 256));
            step();
            if (k == 1) chk("full_pop_no_bypass", count, 3);
            if (k == 2) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        chk("order_count", count, 0);
        chk("order_op_count", op_count, 8);

        // Simultaneous push and pop at count 2
        for (int i = 10; i <= 11; i++) begin
            drive(2'd1, 16'(i), 16'd0, 16'd0, 4'b0000);
            in_valid = 1'b1;
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(2'd1, 16'(12 + i), 16'd0, 16'd0, 4'b0000);
            chk("stream_head", out_result, 32'(10 + i));
            step();
            chk("stream_count", count, 2);
        end
        in_valid = 1'b0;
        chk("stream_tail0", out_result, 16);
        step();
        chk("stream_tail1", out_result, 17);
        step();
        out_ready = 1'b0;
        chk("stream_drained", count, 0);
        chk("stream_op_count", op_count, 16);

        // Sticky clear
        drive(2'd0, 16'h0042, 16'd0, 16'd0, 4'b0001);
        in_valid     = 1'b1;
        sticky_clear = 1'b1;
        step();
        in_valid = 1'b0;
        chk("clr_push_sticky", sticky_flags, 4'b0001);
        chk("clr_push_err", err_count, 2);
        step();
        sticky_clear = 1'b0;
        chk("clr_alone_sticky", sticky_flags, 4'b0000);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step();
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        chk("sat_err", err_count, 255);
        chk("sat_op_count", op_count, 317);
        chk("sat_sticky", sticky_flags, 4'b0001);
        chk("sat_count", count, 0);

        // Reset mid-operation
        for (int i = 1; i <= 3; i++) begin
            drive(2'd0, 16'(16'hA0 + i), 16'd0, 16'd0, 4'b0000);
            in_valid = 1'b1;
            step();
        end
        chk("pre_rst_count", count, 3);
        drive(2'd0, 16'h00A4, 16'd0, 16'd0, 4'b0000);
        out_ready = 1'b1;
        rst_n     = 1'b0;
        step();
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_op", op_count, 0);
        chk("mid_rst_err", err_count, 0);
        chk("mid_rst_sticky", sticky_flags, 0);
        chk("mid_rst_out_result", out_result, 0);
        drive(2'd1, 16'h00B7, 16'd0, 16'd0, 4'b0000);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_head", out_result, 16'h00B7);
        chk("post_rst_sel", out_sel_arith, 2'd1);
        chk("post_rst_count", count, 1);
        chk("post_rst_op", op_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
